// File: rtl/hqm_mem_pg_pkg.sv
// Purpose: shared types, default delays and helpers for the HQM memory
//          power-gate sequencer.
// Contents: state enum, registered-output bundle, counter-width function,
//           state-to-output decode.
package hqm_mem_pg_pkg;

  localparam int unsigned PG_ISO_DLY_DEF     = 4;
  localparam int unsigned PG_RST_DLY_DEF     = 8;
  localparam int unsigned PG_ACK_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    PG_OFF     = 3'd0,
    PG_UP_WAIT = 3'd1,
    PG_DEISO   = 3'd2,
    PG_RST_REL = 3'd3,
    PG_ON      = 3'd4,
    PG_DRAIN   = 3'd5,
    PG_ISO     = 3'd6,
    PG_DN_WAIT = 3'd7
  } hqm_mem_pg_state_t;

  // Power-side outputs, all registered together from the next state.
  typedef struct packed {
    logic pwr_enable_b;
    logic isol_en;
    logic ip_reset_b;
    logic access_en;
    logic dn_ack;
  } hqm_mem_pg_out_t;

  localparam hqm_mem_pg_out_t PG_OUT_OFF = '{pwr_enable_b: 1'b1, isol_en: 1'b1,
                                             ip_reset_b: 1'b0, access_en: 1'b0,
                                             dn_ack: 1'b1};

  // Counter must hold the largest of the delay/timeout values.
  function automatic int unsigned pg_cnt_width(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // dn_ack only flips once a sequence completes, so it stays high through
  // the power-up states and low through the power-down states.
  function automatic hqm_mem_pg_out_t pg_decode(input hqm_mem_pg_state_t st);
    hqm_mem_pg_out_t o;
    o = PG_OUT_OFF;
    case (st)
      PG_OFF:     o = PG_OUT_OFF;
      PG_UP_WAIT: o = '{pwr_enable_b: 1'b0, isol_en: 1'b1, ip_reset_b: 1'b0, access_en: 1'b0, dn_ack: 1'b1};
      PG_DEISO:   o = '{pwr_enable_b: 1'b0, isol_en: 1'b0, ip_reset_b: 1'b0, access_en: 1'b0, dn_ack: 1'b1};
      PG_RST_REL: o = '{pwr_enable_b: 1'b0, isol_en: 1'b0, ip_reset_b: 1'b1, access_en: 1'b0, dn_ack: 1'b1};
      PG_ON:      o = '{pwr_enable_b: 1'b0, isol_en: 1'b0, ip_reset_b: 1'b1, access_en: 1'b1, dn_ack: 1'b0};
      PG_DRAIN:   o = '{pwr_enable_b: 1'b0, isol_en: 1'b0, ip_reset_b: 1'b1, access_en: 1'b0, dn_ack: 1'b0};
      PG_ISO:     o = '{pwr_enable_b: 1'b0, isol_en: 1'b1, ip_reset_b: 1'b0, access_en: 1'b0, dn_ack: 1'b0};
      PG_DN_WAIT: o = '{pwr_enable_b: 1'b1, isol_en: 1'b1, ip_reset_b: 1'b0, access_en: 1'b0, dn_ack: 1'b0};
      default:    o = PG_OUT_OFF;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/hqm_mem_pg_ack_sync.sv
// Purpose: 2-flop synchronizer for the power-chain acknowledge.
// Ports:
//   clk, rst_n : clock, async active-low reset (flops reset to 1 = chain off)
//   i_async    : asynchronous acknowledge from the last wrapper
//   o_sync     : acknowledge synchronized to clk
module hqm_mem_pg_ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_meta <= 2'b11;
    else        r_meta <= {r_meta[0], i_async};
  end

  assign o_sync = r_meta[1];

endmodule

// File: rtl/hqm_mem_pg_seq.sv
// Purpose: power-gate sequencer for a chain of HQM power-gated memory
//          wrappers; drives power enable, isolation and reset, and gates
//          functional access while the arrays are not fully powered.
// Ports:
//   clk, rst_n        : clock, async active-low reset (forces OFF)
//   pwr_dn_req        : level request, 1 = power down
//   pwr_dn_ack        : level acknowledge, follows req when sequence done
//   mem_idle          : no memory read/write in flight
//   mem_access_en     : functional we/re permitted
//   pwr_enable_b      : to first wrapper pwr_enable_b_in (1 = off)
//   pwr_enable_b_ack  : from last wrapper pwr_enable_b_out (async)
//   pgcb_isol_en      : wrapper isolation enable
//   ip_reset_b        : wrapper reset (active low)
//   pg_err            : one-cycle pulse on acknowledge timeout
module hqm_mem_pg_seq
  import hqm_mem_pg_pkg::*;
#(
  parameter int unsigned ISO_DLY     = PG_ISO_DLY_DEF,
  parameter int unsigned RST_DLY     = PG_RST_DLY_DEF,
  parameter int unsigned ACK_TIMEOUT = PG_ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwr_dn_req,
  output logic pwr_dn_ack,
  input  logic mem_idle,
  output logic mem_access_en,
  output logic pwr_enable_b,
  input  logic pwr_enable_b_ack,
  output logic pgcb_isol_en,
  output logic ip_reset_b,
  output logic pg_err
);

  localparam int unsigned CNT_W = pg_cnt_width(ISO_DLY, RST_DLY, ACK_TIMEOUT);
  // Loads are N-1: the state is left on the edge that sees the counter at 0.
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] ACK_LD = (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);
  localparam bit               TO_EN  = (ACK_TIMEOUT != 0);

  hqm_mem_pg_state_t r_state;
  hqm_mem_pg_state_t w_state_nxt;
  hqm_mem_pg_out_t   r_out;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_pg_err;
  logic              w_timeout;
  logic              w_ack_sync;
  logic              w_cnt_zero;

  hqm_mem_pg_ack_sync u_ack_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (pwr_enable_b_ack),
    .o_sync  (w_ack_sync)
  );

  assign w_cnt_zero = (r_cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PG_OFF;
    else        r_state <= w_state_nxt;
  end

  // Next state; a timeout advances as if the ack had arrived.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      PG_OFF:     if (!pwr_dn_req) w_state_nxt = PG_UP_WAIT;
      PG_UP_WAIT: begin
        if (!w_ack_sync) begin
          w_state_nxt = PG_DEISO;
        end else if (TO_EN && w_cnt_zero) begin
          w_state_nxt = PG_DEISO;
          w_timeout   = 1'b1;
        end
      end
      PG_DEISO:   if (w_cnt_zero) w_state_nxt = PG_RST_REL;
      PG_RST_REL: if (w_cnt_zero) w_state_nxt = PG_ON;
      PG_ON:      if (pwr_dn_req) w_state_nxt = PG_DRAIN;
      // Abort wins over idle: nothing has been powered down yet.
      PG_DRAIN: begin
        if (!pwr_dn_req)   w_state_nxt = PG_ON;
        else if (mem_idle) w_state_nxt = PG_ISO;
      end
      PG_ISO:     if (w_cnt_zero) w_state_nxt = PG_DN_WAIT;
      PG_DN_WAIT: begin
        if (w_ack_sync) begin
          w_state_nxt = PG_OFF;
        end else if (TO_EN && w_cnt_zero) begin
          w_state_nxt = PG_OFF;
          w_timeout   = 1'b1;
        end
      end
      default:    w_state_nxt = PG_OFF;
    endcase
  end

  // Shared delay/timeout counter: reload on entry, else count down to 0.
  always_comb begin
    w_cnt_nxt = w_cnt_zero ? '0 : r_cnt - CNT_W'(1);
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        PG_DEISO, PG_ISO:       w_cnt_nxt = ISO_LD;
        PG_RST_REL:             w_cnt_nxt = RST_LD;
        PG_UP_WAIT, PG_DN_WAIT: w_cnt_nxt = ACK_LD;
        default:                w_cnt_nxt = '0;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= PG_OUT_OFF;
      r_cnt    <= '0;
      r_pg_err <= 1'b0;
    end else begin
      r_out    <= pg_decode(w_state_nxt);
      r_cnt    <= w_cnt_nxt;
      r_pg_err <= w_timeout;
    end
  end

  assign pwr_enable_b  = r_out.pwr_enable_b;
  assign pgcb_isol_en  = r_out.isol_en;
  assign ip_reset_b    = r_out.ip_reset_b;
  assign mem_access_en = r_out.access_en;
  assign pwr_dn_ack    = r_out.dn_ack;
  assign pg_err        = r_pg_err;

endmodule

// File: tb/tb_hqm_mem_pg_seq.sv
// Purpose: self-checking bench for hqm_mem_pg_seq (default parameters,
//          zero-delay ack loopback unless the ack is forced high).
module tb_hqm_mem_pg_seq;

  logic clk;
  logic rst_n;
  logic pwr_dn_req;
  logic pwr_dn_ack;
  logic mem_idle;
  logic mem_access_en;
  logic pwr_enable_b;
  logic pwr_enable_b_ack;
  logic pgcb_isol_en;
  logic ip_reset_b;
  logic pg_err;
  logic ack_hi;

  int n_chk = 0;
  int n_err = 0;

  // Observed bundle: {access, dn_ack, pwr_enable_b, isol, ip_reset_b, pg_err}
  logic [5:0] obs;
  assign obs = {mem_access_en, pwr_dn_ack, pwr_enable_b, pgcb_isol_en, ip_reset_b, pg_err};

  localparam logic [5:0] E_OFF  = 6'b011100;
  localparam logic [5:0] E_UPW  = 6'b010100;
  localparam logic [5:0] E_DEI  = 6'b010000;
  localparam logic [5:0] E_RSTR = 6'b010010;
  localparam logic [5:0] E_ON   = 6'b100010;
  localparam logic [5:0] E_DRN  = 6'b000010;
  localparam logic [5:0] E_ISO  = 6'b000100;
  localparam logic [5:0] E_DNW  = 6'b001100;

  assign pwr_enable_b_ack = ack_hi ? 1'b1 : pwr_enable_b;

  hqm_mem_pg_seq #(
    .ISO_DLY     (4),
    .RST_DLY     (8),
    .ACK_TIMEOUT (64)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pwr_dn_req       (pwr_dn_req),
    .pwr_dn_ack       (pwr_dn_ack),
    .mem_idle         (mem_idle),
    .mem_access_en    (mem_access_en),
    .pwr_enable_b     (pwr_enable_b),
    .pwr_enable_b_ack (pwr_enable_b_ack),
    .pgcb_isol_en     (pgcb_isol_en),
    .ip_reset_b       (ip_reset_b),
    .pg_err           (pg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned n;
    logic        req;
    logic        idle;
    logic [5:0]  exp;
  } vec_t;

  vec_t vt[$];

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (acc,ack,pwrb,isol,rstb,err)", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic hi);
    rst_n      = 1'b0;
    ack_hi     = hi;
    pwr_dn_req = 1'b0;
    mem_idle   = 1'b1;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errcnt;

    // {edges to advance, req, idle, expected bundle after those edges}
    vt.push_back('{n: 1,  req: 1'b0, idle: 1'b1, exp: E_UPW});
    vt.push_back('{n: 2,  req: 1'b0, idle: 1'b1, exp: E_UPW});
    vt.push_back('{n: 1,  req: 1'b0, idle: 1'b1, exp: E_DEI});
    vt.push_back('{n: 3,  req: 1'b0, idle: 1'b1, exp: E_DEI});
    vt.push_back('{n: 1,  req: 1'b0, idle: 1'b1, exp: E_RSTR});
    vt.push_back('{n: 7,  req: 1'b0, idle: 1'b1, exp: E_RSTR});
    vt.push_back('{n: 1,  req: 1'b0, idle: 1'b1, exp: E_ON});
    vt.push_back('{n: 1,  req: 1'b1, idle: 1'b0, exp: E_DRN});
    vt.push_back('{n: 9,  req: 1'b1, idle: 1'b0, exp: E_DRN});
    vt.push_back('{n: 1,  req: 1'b1, idle: 1'b1, exp: E_ISO});
    vt.push_back('{n: 3,  req: 1'b1, idle: 1'b1, exp: E_ISO});
    vt.push_back('{n: 1,  req: 1'b1, idle: 1'b1, exp: E_DNW});
    vt.push_back('{n: 2,  req: 1'b1, idle: 1'b1, exp: E_DNW});
    vt.push_back('{n: 1,  req: 1'b1, idle: 1'b1, exp: E_OFF});
    vt.push_back('{n: 3,  req: 1'b1, idle: 1'b1, exp: E_OFF});
    vt.push_back('{n: 15, req: 1'b0, idle: 1'b1, exp: E_RSTR});
    vt.push_back('{n: 1,  req: 1'b0, idle: 1'b1, exp: E_ON});
    vt.push_back('{n: 1,  req: 1'b1, idle: 1'b0, exp: E_DRN});
    vt.push_back('{n: 1,  req: 1'b0, idle: 1'b0, exp: E_ON});
    vt.push_back('{n: 2,  req: 1'b0, idle: 1'b0, exp: E_ON});

    // Reset values, then the main table from reset release.
    rst_n = 1'b0; ack_hi = 1'b0; pwr_dn_req = 1'b0; mem_idle = 1'b1;
    #12;
    chk("reset_vals", obs, E_OFF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      pwr_dn_req = vt[i].req;
      mem_idle   = vt[i].idle;
      tick(vt[i].n);
      chk($sformatf("vec%0d", i), obs, vt[i].exp);
    end

    // req drops during ISO: still completes to OFF, then powers straight up.
    pwr_dn_req = 1'b1; mem_idle = 1'b1;
    tick(2);
    chk("isoreq_iso", obs, E_ISO);
    pwr_dn_req = 1'b0;
    tick(6);
    chk("isoreq_dnw", obs, E_DNW);
    tick(1);
    chk("isoreq_off", obs, E_OFF);
    tick(1);
    chk("isoreq_upw", obs, E_UPW);
    tick(14);
    chk("isoreq_rstr", obs, E_RSTR);
    tick(1);
    chk("isoreq_on", obs, E_ON);

    // Ack stuck high during power-up: one pg_err pulse, still reaches ON.
    do_reset(1'b1);
    errcnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (pg_err) errcnt++;
    end
    chk("to_wait64", obs, E_UPW);
    tick(1);
    if (pg_err) errcnt++;
    chk("to_edge65", obs, E_DEI | 6'b000001);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (pg_err) errcnt++;
      if (mem_access_en) break;
    end
    chk("to_reach_on", obs, E_ON);
    chk_int("to_err_pulses", errcnt, 1);
    ack_hi = 1'b0;

    // Reset asserted mid RST_REL forces OFF outputs without a clock edge.
    do_reset(1'b0);
    tick(10);
    chk("arst_pre", obs, E_RSTR);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_async", obs, E_OFF);
    #20;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
